// File: rtl/piano_pkg.sv
// Shared definitions for the piano-tile lane logic.
//   judge_state_e : lane judge FSM state encoding
//   KEY_LANE0..3  : keyboard keycodes assigned to the four lanes
//   SCREEN_Y_MAX  : bottom visible screen row
//   TILE_H        : default falling tile height
//   sat_inc8      : 8-bit increment that holds at 255
package piano_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SPAWN   = 3'd1,
        ST_FALLING = 3'd2,
        ST_HIT     = 3'd3,
        ST_MISS    = 3'd4
    } judge_state_e;

    localparam logic [7:0] KEY_LANE0    = 8'h07;
    localparam logic [7:0] KEY_LANE1    = 8'h09;
    localparam logic [7:0] KEY_LANE2    = 8'h0D;
    localparam logic [7:0] KEY_LANE3    = 8'h0E;

    localparam logic [9:0] SCREEN_Y_MAX = 10'd479;
    localparam logic [9:0] TILE_H       = 10'd75;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/key_edge.sv
// Rising-edge detector for one lane key.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset
//   keycode_i : current keyboard keycode (8'h00 = no key)
//   rise_o    : high for the first cycle the lane key is seen; a held key
//               produces no further rises until it is released
module key_edge #(
    parameter logic [7:0] KEY = 8'h0E
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] keycode_i,
    output logic       rise_o
);

    logic key_match;
    logic key_prev_q;

    assign key_match = (keycode_i == KEY);
    assign rise_o    = key_match && !key_prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            key_prev_q <= 1'b0;
        end else begin
            key_prev_q <= key_match;
        end
    end

endmodule

// File: rtl/lane_judge.sv
// Judge for one piano-tile lane: launches a tile, watches it fall and
// decides hit or miss from the lane key and the tile position.
//   frame_clk : clock
//   Reset     : synchronous active-high reset
//   spawn_req : launch request from the song sequencer (one deep queue)
//   keycode   : current keyboard keycode
//   tile_y    : tile top row;  tile_s : tile height
//   newNote   : restart tile at top;  kill : park tile off-screen
//   hit/miss  : judgement pulses;  busy : tile live
//   hit_cnt/miss_cnt : saturating judgement counters
//
// state      | meaning
// -----------+------------------------------------------------
// ST_IDLE    | no tile live, waiting for a spawn request
// ST_SPAWN   | newNote pulse, tile restarts at the top
// ST_FALLING | tile falling, judging key and position
// ST_HIT     | kill + hit pulse
// ST_MISS    | kill + miss pulse (late, early or bottomed out)
module lane_judge
    import piano_pkg::*;
#(
    parameter logic [7:0] LANE_KEY  = KEY_LANE3,
    parameter logic [9:0] HIT_Y_MIN = 10'd300,
    parameter logic [9:0] Y_MAX     = SCREEN_Y_MAX
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       spawn_req,
    input  logic [7:0] keycode,
    input  logic [9:0] tile_y,
    input  logic [9:0] tile_s,
    output logic       newNote,
    output logic       kill,
    output logic       hit,
    output logic       miss,
    output logic       busy,
    output logic [7:0] hit_cnt,
    output logic [7:0] miss_cnt
);

    judge_state_e state_q, state_d;
    logic         pending_q, pending_d;
    logic [7:0]   hit_cnt_q, hit_cnt_d;
    logic [7:0]   miss_cnt_q, miss_cnt_d;
    logic         key_rise;
    logic [10:0]  tile_bottom;
    logic         bottomed;

    key_edge #(
        .KEY(LANE_KEY)
    ) u_key_edge (
        .clk_i    (frame_clk),
        .rst_i    (Reset),
        .keycode_i(keycode),
        .rise_o   (key_rise)
    );

    // Widened so a large y plus height cannot wrap back on-screen.
    assign tile_bottom = {1'b0, tile_y} + {1'b0, tile_s};
    assign bottomed    = (tile_bottom >= {1'b0, Y_MAX});

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;

        // A request arriving while a tile is live is remembered once.
        if (state_q != ST_IDLE && spawn_req) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (spawn_req || pending_q) begin
                    state_d   = ST_SPAWN;
                    pending_d = 1'b0;
                end
            end
            ST_SPAWN: begin
                state_d = ST_FALLING;
            end
            ST_FALLING: begin
                // Counters move on entry so they are current with the pulse.
                if (key_rise && (tile_y >= HIT_Y_MIN)) begin
                    state_d   = ST_HIT;
                    hit_cnt_d = sat_inc8(hit_cnt_q);
                end else if (bottomed || key_rise) begin
                    state_d    = ST_MISS;
                    miss_cnt_d = sat_inc8(miss_cnt_q);
                end
            end
            ST_HIT:  state_d = ST_IDLE;
            ST_MISS: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            pending_q  <= 1'b0;
            hit_cnt_q  <= 8'd0;
            miss_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Moore outputs, forced quiet while reset is held so an interrupted
    // tile never sees a kill.
    assign newNote  = !Reset && (state_q == ST_SPAWN);
    assign kill     = !Reset && ((state_q == ST_HIT) || (state_q == ST_MISS));
    assign hit      = !Reset && (state_q == ST_HIT);
    assign miss     = !Reset && (state_q == ST_MISS);
    assign busy     = !Reset && (state_q != ST_IDLE);
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_lane_judge.sv
module tb_lane_judge;

    localparam logic [7:0] KEY = 8'h0E;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic       spawn_req;
    logic [7:0] keycode;
    logic [9:0] tile_y;
    logic [9:0] tile_s;
    logic       newNote, kill, hit, miss, busy;
    logic [7:0] hit_cnt, miss_cnt;

    int errors = 0;
    int checks = 0;

    // {newNote, kill, hit, miss, hit_cnt, miss_cnt}
    logic [19:0] sb_q[$];
    logic [7:0]  m_hit, m_miss;

    lane_judge dut (
        .frame_clk(frame_clk),
        .Reset    (Reset),
        .spawn_req(spawn_req),
        .keycode  (keycode),
        .tile_y   (tile_y),
        .tile_s   (tile_s),
        .newNote  (newNote),
        .kill     (kill),
        .hit      (hit),
        .miss     (miss),
        .busy     (busy),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] ev(input logic n, input logic k, input logic h,
                                       input logic m, input logic [7:0] hc,
                                       input logic [7:0] mc);
        return {n, k, h, m, hc, mc};
    endfunction

    function automatic logic [7:0] sat(input logic [7:0] v);
        return (v == 8'd255) ? 8'd255 : v + 8'd1;
    endfunction

    // Every pulse must match the oldest expected event.
    always @(negedge frame_clk) begin
        logic [19:0] obs;
        obs = {newNote, kill, hit, miss, hit_cnt, miss_cnt};
        if (newNote || kill || hit || miss) begin
            if (sb_q.size() == 0) chk("unexpected_pulse", {12'd0, obs}, 32'd0);
            else                  chk("event", {12'd0, obs}, {12'd0, sb_q.pop_front()});
        end
    end

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    // Leaves the DUT in FALLING.
    task automatic spawn_tile();
        spawn_req = 1'b1;
        sb_q.push_back(ev(1, 0, 0, 0, m_hit, m_miss));
        tick();
        spawn_req = 1'b0;
        chk("busy_spawn", {31'd0, busy}, 32'd1);
        tick();
    endtask

    task automatic strike_hit();
        keycode = KEY;
        m_hit = sat(m_hit);
        sb_q.push_back(ev(0, 1, 1, 0, m_hit, m_miss));
        tick();
        keycode = 8'h00;
        tick();
    endtask

    task automatic expect_miss();
        m_miss = sat(m_miss);
        sb_q.push_back(ev(0, 1, 0, 1, m_hit, m_miss));
        tick();
    endtask

    initial begin
        Reset = 1'b1; spawn_req = 1'b0; keycode = 8'h00;
        tile_y = 10'd0; tile_s = 10'd75;
        m_hit = 8'd0; m_miss = 8'd0;
        repeat (3) tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_kill", {31'd0, kill}, 32'd0);
        chk("rst_hit_cnt", {24'd0, hit_cnt}, 32'd0);
        chk("rst_miss_cnt", {24'd0, miss_cnt}, 32'd0);
        Reset = 1'b0;
        tick();

        // Basic spawn then hit at y=320.
        spawn_tile();
        chk("busy_falling", {31'd0, busy}, 32'd1);
        tile_y = 10'd320;
        strike_hit();
        chk("idle_after_hit", {31'd0, busy}, 32'd0);
        tile_y = 10'd0;
        tick();

        // Bottom boundary: 403+75=478 holds, 404+75=479 misses.
        spawn_tile();
        tile_y = 10'd403;
        repeat (3) tick();
        chk("no_miss_478", {31'd0, busy}, 32'd1);
        tile_y = 10'd404;
        expect_miss();
        tile_y = 10'd0;
        tick();
        chk("idle_after_miss", {31'd0, busy}, 32'd0);

        // Early strike at y=100, key held afterwards.
        spawn_tile();
        tile_y = 10'd100;
        keycode = KEY;
        expect_miss();
        repeat (3) tick();
        chk("held_idle", {31'd0, busy}, 32'd0);

        // Key held through IDLE/SPAWN gives no rise in FALLING.
        spawn_tile();
        tile_y = 10'd350;
        repeat (3) tick();
        chk("held_no_hit", {31'd0, busy}, 32'd1);
        keycode = 8'h00;
        tick();

        // Hit window lower edge: 299 is early, 300 is a hit.
        tile_y = 10'd299;
        keycode = KEY;
        expect_miss();
        keycode = 8'h00;
        tick();
        spawn_tile();
        tile_y = 10'd300;
        strike_hit();

        // Sum needs 11 bits: 1023+10 would wrap to 9.
        tile_y = 10'd0;
        spawn_tile();
        tile_y = 10'd1023; tile_s = 10'd10;
        expect_miss();
        tile_y = 10'd0; tile_s = 10'd75;
        tick();

        // Two requests while falling: one extra tile, the second dropped.
        spawn_tile();
        spawn_req = 1'b1; tick(); spawn_req = 1'b0;
        tick();
        spawn_req = 1'b1; tick(); spawn_req = 1'b0;
        tile_y = 10'd320;
        strike_hit();
        sb_q.push_back(ev(1, 0, 0, 0, m_hit, m_miss));
        tick();
        tick();
        chk("pending_falling", {31'd0, busy}, 32'd1);
        repeat (4) tick();
        tile_y = 10'd450;
        expect_miss();
        tile_y = 10'd0;
        repeat (5) tick();
        chk("pending_drained", {31'd0, busy}, 32'd0);

        // Spawn request in the same cycle as a hit goes to pending.
        spawn_tile();
        tile_y = 10'd310;
        spawn_req = 1'b1;
        strike_hit();
        spawn_req = 1'b0;
        sb_q.push_back(ev(1, 0, 0, 0, m_hit, m_miss));
        tick();
        tick();
        tile_y = 10'd470;
        expect_miss();
        tile_y = 10'd0;
        repeat (3) tick();

        // Saturation of hit_cnt.
        Reset = 1'b1; tick(); Reset = 1'b0;
        m_hit = 8'd0; m_miss = 8'd0;
        tick();
        for (int i = 0; i < 255; i++) begin
            tile_y = 10'd0;
            spawn_tile();
            tile_y = 10'd320;
            strike_hit();
        end
        chk("hit_cnt_255", {24'd0, hit_cnt}, 32'd255);
        tile_y = 10'd0;
        spawn_tile();
        tile_y = 10'd320;
        strike_hit();
        chk("hit_cnt_sat", {24'd0, hit_cnt}, 32'd255);

        // Reset mid-FALLING with a pending request.
        tile_y = 10'd0;
        spawn_tile();
        spawn_req = 1'b1; tick(); spawn_req = 1'b0;
        Reset = 1'b1;
        #0;
        chk("rst_gate_busy", {31'd0, busy}, 32'd0);
        chk("rst_gate_kill", {31'd0, kill}, 32'd0);
        tick();
        chk("rst_mid_hit_cnt", {24'd0, hit_cnt}, 32'd0);
        chk("rst_mid_miss_cnt", {24'd0, miss_cnt}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        Reset = 1'b0;
        m_hit = 8'd0; m_miss = 8'd0;
        repeat (6) tick();
        chk("rst_pending_cleared", {31'd0, busy}, 32'd0);

        repeat (2) tick();
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lane_judge.md
LANE_JUDGE -- requirements
Module: lane_judge

Interface
REQ-001 Parameter LANE_KEY, 8'h0E, keyboard keycode that strikes this lane.
REQ-002 Parameter HIT_Y_MIN, 10'd300, lowest tile_y (top edge) accepted as a hit.
REQ-003 Parameter Y_MAX, 10'd479, bottom screen row; a tile whose bottom reaches it is missed.
REQ-004 frame_clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 spawn_req  input  1  one-cycle request from the song sequencer to launch a tile in this lane.
REQ-007 keycode  input  8  current keyboard keycode; 8'h00 means no key.
REQ-008 tile_y  input  10  falling tile's top Y position, driven by the tile's Y output.
REQ-009 tile_s  input  10  falling tile's height, driven by the tile's size output.
REQ-010 newNote  output  1  one-cycle pulse that restarts the tile at the top.
REQ-011 kill  output  1  one-cycle pulse that parks the tile off-screen.
REQ-012 hit  output  1  one-cycle pulse on a successful strike.
REQ-013 miss  output  1  one-cycle pulse on a late, early or bottomed-out tile.
REQ-014 busy  output  1  high while a tile is live (any state other than IDLE).
REQ-015 hit_cnt  output  8  saturating count of hits.
REQ-016 miss_cnt  output  8  saturating count of misses.

Function
REQ-017 FSM states: IDLE, SPAWN, FALLING, HIT, MISS; all outputs are Moore-decoded from registered state.
REQ-018 IDLE -> SPAWN when spawn_req=1 or pending=1; consume pending on that transition.
REQ-019 SPAWN: newNote=1 for exactly one cycle, then -> FALLING unconditionally; tile_y is not evaluated in SPAWN.
REQ-020 key_rise = (keycode==LANE_KEY) && !key_prev; key_prev is registered every cycle in every state.
REQ-021 In FALLING, evaluate in priority order: key_rise && tile_y>=HIT_Y_MIN -> HIT; else tile_y+tile_s >= Y_MAX -> MISS; else key_rise -> MISS (early); else stay.
REQ-022 Compute tile_y+tile_s at 11 bits; no wrap-around permitted.
REQ-023 HIT: kill=1 and hit=1 for one cycle; hit_cnt increments, saturating at 255; -> IDLE.
REQ-024 MISS: kill=1 and miss=1 for one cycle; miss_cnt increments, saturating at 255; -> IDLE.
REQ-025 Latency: a qualifying condition sampled in cycle n produces its pulse in cycle n+1; spawn_req in IDLE at cycle n produces newNote at n+1.
REQ-026 spawn_req while not IDLE sets pending (one-deep); further requests while pending=1 are dropped.
REQ-027 key_rise in IDLE or SPAWN has no effect; a held key produces at most one key_rise.
REQ-028 spawn_req and a FALLING event in the same cycle: the event is processed and the request goes to pending.

Reset
REQ-029 Reset=1 at any edge, including mid-FALLING, forces IDLE, pending=0, key_prev=0, hit_cnt=0, miss_cnt=0.
REQ-030 While Reset=1, all pulse outputs and busy are 0; no kill is issued on reset.

Structure
REQ-031 Shared package piano_pkg holds the state enum, lane keycodes (8'h07, 8'h09, 8'h0D, 8'h0E), SCREEN_Y_MAX=479 and TILE_H=75.
REQ-032 Key edge detection is a sub-module key_edge (key_prev register plus rise output) so all four lanes reuse it.

Verification
REQ-033 Reset, then spawn_req at cycle 5 -> newNote=1 in cycle 6 only, busy=1 from cycle 6.
REQ-034 FALLING, tile_y=320, keycode 00->0E -> next cycle kill=1, hit=1, hit_cnt=1, then IDLE.
REQ-035 FALLING, tile_y=404, tile_s=75, no key -> next cycle kill=1, miss=1, miss_cnt=1.
REQ-036 FALLING, tile_y=100, keycode rises to 0E -> early MISS; keycode held at 0E afterwards -> no further pulses.
REQ-037 spawn_req twice during FALLING -> one extra newNote after return to IDLE, second request dropped.
REQ-038 hit_cnt preloaded to 255 via 255 hits -> 256th hit leaves 255; Reset mid-FALLING -> IDLE, counters 0, no kill.
